muldiv_controller: RTL
======================

Name: muldiv_controller

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, alongside the single-cycle ALU in EX. It accepts one operation from EX, iterates one bit per cycle, and owns the HI/LO architectural registers. It also supports MTHI/MTLO writes. Busy drives the hazard unit, which stalls dependent MFHI/MFLO and further mul/div issue.

Parameters:
WIDTH, 32, operand width (fixed 32 for MIPS; counter width derived as clog2(WIDTH)+1)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request new operation; sampled only when idle
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  32  rs operand (multiplicand / dividend)
B  input  32  rt operand (multiplier / divisor)
WriteHi  input  1  MTHI: load WriteData into HI
WriteLo  input  1  MTLO: load WriteData into LO
WriteData  input  32  MTHI/MTLO data
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse, HI/LO just updated by an operation
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Clocking: one clock (Clk); Reset synchronous, active-high; everything updates on rising Clk.
- Reset value: state IDLE; HI=0, LO=0, Busy=0, Done=0; all internal registers 0.
- Reset is dominant at any time, including mid-operation: the next edge gives IDLE with HI/LO=0, and no Done pulse.
- States:
  - IDLE: Busy=0.
  - CALC: Busy=1; iteration counter 0..31.
  - FIX: Busy=1; sign correction and HI/LO writeback.
- Transitions:
  - IDLE→CALC on edge N with Start=1. Latch Op, |A| and |B| (magnitudes only for signed ops), sign(A), sign(B), original A; clear counter.
  - CALC: one iteration per edge, edges N+1..N+32. Counter==31 → FIX.
  - FIX→IDLE at edge N+33: write HI/LO, set Done=1 for the cycle after edge N+33 only.
- Latency: result visible in HI/LO after edge N+33 (33 cycles). Busy high from after edge N through edge N+33. Start is accepted again in the Done cycle.
- Multiply (shift-add): 64-bit product register {upper, lower}; lower initialised to |B|. Each iteration: if lower bit0, upper33 = upper + M (33-bit sum, carry kept); then shift the 65-bit value right 1.
- Multiply result: MULT negates the 64-bit product in FIX if sign(A)≠sign(B). HI=product[63:32], LO=product[31:0].
- Divide (restoring): 33-bit remainder, 32-bit quotient shift register initialised to |A|. Each iteration: shift {rem,quot} left 1; trial = rem − {0,|B|}; if trial ≥ 0, rem=trial and quot bit0=1.
- Divide result: DIV negates the quotient if signs differ; the remainder takes sign(A). LO=quotient, HI=remainder.
- Divide by zero: same 33-cycle timing; LO=32'hFFFFFFFF, HI=original A. Applies to signed and unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- Start while Busy: ignored, not queued.
- WriteHi/WriteLo while Busy: ignored.
- WriteHi/WriteLo while idle: write on the next edge. Both may be asserted together.
- Start and WriteHi/WriteLo in the same idle cycle: Start wins and the writes are dropped.
- Op/A/B changes after the Start cycle have no effect.

Decomposition:
- Shared include/package: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings, WIDTH.
- One natural sub-module: muldiv_datapath. It holds the product/remainder shift registers, the 33-bit adder/subtractor and sign-fix negation, with an iterate/load/fix control from the FSM.
- The FSM, counter and HI/LO registers stay in muldiv_controller.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, Start at edge N → Busy 1 from N+1, Done pulse after N+33, HI=0xFFFFFFFE, LO=0x00000001.
2. MULT A=0xFFFFFFFD (−3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=100, B=0 → 33 cycles, LO=0xFFFFFFFF, HI=0x00000064; DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
4. Reset asserted at cycle N+10 of a MULT → Busy=0, HI=LO=0 after that edge, no Done pulse ever; a new Start afterwards completes normally.
5. Second Start (MULTU 2×3) at N+5 during DIVU 9/4 → ignored: LO=2, HI=1. WriteHi=1, WriteData=0x1234 mid-op → ignored. The same write while idle → HI=0x1234 next edge, LO unchanged.
6. Back-to-back: Start MULTU 7×6 in the Done cycle of a previous op → accepted, HI=0, LO=42 after 33 more cycles. Start+WriteLo in the same idle cycle → LO not written by WriteLo.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MIPS multiply/divide unit:
// operand width, iteration counter sizing, op and state encodings.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to 2^31, which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath. Holds the latched
// operands, the shared {upper/remainder, lower/quotient} shift registers,
// one 33-bit adder/subtractor and the final sign correction.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_iter,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  op_e              r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_orig_a;
  logic [WIDTH-1:0] r_operand;  // |A| (multiplicand) or |B| (divisor)
  logic [WIDTH:0]   r_hi;       // product upper half or 33-bit remainder
  logic [WIDTH-1:0] r_lo;       // product lower half or quotient

  logic             w_is_div;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_addsub;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_div = is_div_op(r_op);
  assign w_sgn_a  = is_signed_op(op_e'(i_op)) & i_a[WIDTH-1];
  assign w_sgn_b  = is_signed_op(op_e'(i_op)) & i_b[WIDTH-1];
  assign w_mag_a  = magnitude(i_a, w_sgn_a);
  assign w_mag_b  = magnitude(i_b, w_sgn_b);

  // Divide: remainder shifted left with the next dividend bit. Since the
  // remainder stays below the divisor, bit 32 of the difference is set
  // exactly when the trial subtraction goes negative.
  assign w_rem_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_addsub = w_is_div
                  ? (w_rem_sh - {1'b0, r_operand})
                  : ({1'b0, r_hi[WIDTH-1:0]} + (r_lo[0] ? {1'b0, r_operand} : '0));

  // Operand latch on load, one shift-add or restoring-divide step per iterate.
  always_ff @(posedge i_clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      r_op      <= OP_MULT;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_orig_a  <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (i_load) begin
      r_op      <= op_e'(i_op);
      r_neg_a   <= w_sgn_a;
      r_neg_b   <= w_sgn_b;
      r_b_zero  <= (i_b == '0);
      r_orig_a  <= i_a;
      r_hi      <= '0;
      if (is_div_op(op_e'(i_op))) begin
        r_operand <= w_mag_b;
        r_lo      <= w_mag_a;
      end else begin
        r_operand <= w_mag_a;
        r_lo      <= w_mag_b;
      end
    end else if (i_iter) begin
      if (w_is_div) begin
        if (!w_addsub[WIDTH]) begin
          r_hi <= w_addsub;
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_rem_sh;
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= {1'b0, w_addsub[WIDTH:1]};
        r_lo <= {w_addsub[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = {r_hi[WIDTH-1:0], r_lo};

  // Sign correction and divide-by-zero override for HI/LO writeback.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      if (r_b_zero) begin
        o_hi = r_orig_a;
        o_lo = '1;
      end else begin
        o_lo = (r_neg_a ^ r_neg_b) ? (~r_lo + 1'b1) : r_lo;
        o_hi = r_neg_a ? (~r_hi[WIDTH-1:0] + 1'b1) : r_hi[WIDTH-1:0];
      end
    end else if (r_neg_a ^ r_neg_b) begin
      {o_hi, o_lo} = ~w_prod + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer: IDLE -> CALC (32 iterations) -> FIX,
// owns the HI/LO architectural registers and handles MTHI/MTLO writes.
module muldiv_controller
  import muldiv_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             w_load;
  logic             w_iter;
  logic             w_fix;
  logic             w_idle;
  logic [WIDTH-1:0] w_dp_hi;
  logic [WIDTH-1:0] w_dp_lo;

  muldiv_datapath u_datapath (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_load),
    .i_iter (w_iter),
    .i_op   (Op),
    .i_a    (A),
    .i_b    (B),
    .o_hi   (w_dp_hi),
    .o_lo   (w_dp_lo)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and datapath control.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_iter = 1'b0;
    w_fix  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load = 1'b1;
          w_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_iter = 1'b1;
        if (r_cnt == LAST_ITER) w_next = ST_FIX;
      end
      ST_FIX: begin
        w_fix  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_idle = (r_state == ST_IDLE);

  // Iteration counter: cleared on accept, advanced each CALC cycle.
  always_ff @(posedge Clk) begin
    if (Reset)       r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_iter) r_cnt <= r_cnt + 1'b1;
  end

  // HI/LO: operation writeback wins; MTHI/MTLO only when idle and no Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_dp_hi;
      r_lo <= w_dp_lo;
    end else if (w_idle && !Start) begin
      if (WriteHi) r_hi <= WriteData;
      if (WriteLo) r_lo <= WriteData;
    end
  end

  // Done pulses for the single cycle following writeback.
  always_ff @(posedge Clk) begin
    if (Reset) r_done <= 1'b0;
    else       r_done <= w_fix;
  end

  assign Busy = !w_idle;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
